// File: rtl/alu_pipe_pkg.sv
// Shared opcode and FSM state types for the pipelined ALU.
package alu_pipe_pkg;

  typedef enum logic [3:0] {
    OP_PASS_B = 4'd0,
    OP_PASS_A = 4'd1,
    OP_ADD    = 4'd2,
    OP_SUB    = 4'd3,
    OP_AND    = 4'd4,
    OP_INC    = 4'd5,
    OP_DEC    = 4'd6,
    OP_XOR    = 4'd7,
    OP_NOP    = 4'd8,
    OP_CLR    = 4'd9,
    OP_OR     = 4'd10,
    OP_SWAP   = 4'd11,
    OP_SHL    = 4'd12,
    OP_SHR    = 4'd13,
    OP_MUL    = 4'd14,
    OP_ILL    = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_pipe_iter.sv
// Iterative datapath: one shift step or one shift-add partial product per cycle.
// Multiplier logic exists only when ALU_PIPE_MUL_EN is defined.
module alu_pipe_iter
  import alu_pipe_pkg::*;
#(
  parameter int W   = 8,
  parameter int SHW = $clog2(W)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  alu_op_e      op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W:0]   result
);

  logic           busy_q, busy_d;
  logic           shl_q, shl_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic [W-1:0]   val_q, val_d;
  logic [W:0]     step;

`ifdef ALU_PIPE_MUL_EN
  // val_q doubles as the low product half / remaining multiplier bits
  logic           mul_q, mul_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W:0]     sum;
`else
  logic           unused_b;
  assign unused_b = ^b[W-1:SHW];
`endif

  always_comb begin
    step   = shl_q ? {val_q, 1'b0} : {val_q[0], 1'b0, val_q[W-1:1]};
    done   = busy_q && (cnt_q == '0);
    result = step;
    busy_d = busy_q;
    shl_d  = shl_q;
    cnt_d  = cnt_q;
    val_d  = val_q;
`ifdef ALU_PIPE_MUL_EN
    mul_d   = mul_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    sum     = {1'b0, hi_q} + (val_q[0] ? {1'b0, mcand_q} : '0);
    if (mul_q) result = {|sum[W:1], sum[0], val_q[W-1:1]};
`endif
    if (start) begin
      busy_d = 1'b1;
      shl_d  = (op == OP_SHL);
      val_d  = a;
      cnt_d  = b[SHW-1:0] - SHW'(1);
`ifdef ALU_PIPE_MUL_EN
      mul_d = (op == OP_MUL);
      if (op == OP_MUL) begin
        val_d   = b;
        mcand_d = a;
        hi_d    = '0;
        cnt_d   = SHW'(W - 1);
      end
`endif
    end else if (busy_q) begin
      busy_d = !done;
      cnt_d  = cnt_q - SHW'(1);
      val_d  = step[W-1:0];
`ifdef ALU_PIPE_MUL_EN
      if (mul_q) begin
        val_d = {sum[0], val_q[W-1:1]};
        hi_d  = sum[W:1];
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      shl_q  <= 1'b0;
      cnt_q  <= '0;
      val_q  <= '0;
`ifdef ALU_PIPE_MUL_EN
      mul_q   <= 1'b0;
      mcand_q <= '0;
      hi_q    <= '0;
`endif
    end else begin
      busy_q <= busy_d;
      shl_q  <= shl_d;
      cnt_q  <= cnt_d;
      val_q  <= val_d;
`ifdef ALU_PIPE_MUL_EN
      mul_q   <= mul_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
`endif
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// W-bit ALU with registered result/flags, valid/ready on both sides and iterative shifts.
// Define ALU_PIPE_MUL_EN to enable the multi-cycle multiply on opcode 14.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int W   = 8,
  parameter int SHW = $clog2(W)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   inst,
  input  logic         a_sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   res,
  output logic         zero,
  output logic         err
);

  alu_state_e   state_q, state_d, iter_state;
  logic [W:0]   res_q, res_d, alu_res, iter_res;
  logic         zero_q, zero_d, err_q, err_d, out_valid_q, out_valid_d;
  logic         accept, is_iter, alu_err, iter_done;
  alu_op_e      op;
  logic [W-1:0] op_a;

  assign op        = alu_op_e'(inst);
  assign op_a      = a_sel ? res_q[W-1:0] : a;
  assign in_ready  = !reset && (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign res       = res_q;
  assign zero      = zero_q;
  assign err       = err_q;
  assign out_valid = out_valid_q;

  always_comb begin
    alu_res    = '0;
    alu_err    = 1'b0;
    is_iter    = 1'b0;
    iter_state = SHIFT;
    case (op)
      OP_PASS_B: alu_res = {1'b0, b};
      OP_PASS_A: alu_res = {1'b0, op_a};
      OP_ADD:    alu_res = {1'b0, op_a} + {1'b0, b};
      OP_SUB:    alu_res = {1'b0, op_a} - {1'b0, b};
      OP_AND:    alu_res = {1'b0, op_a & b};
      OP_INC:    alu_res = {1'b0, b} + 1'b1;
      OP_DEC:    alu_res = {1'b0, b} - 1'b1;
      OP_XOR:    alu_res = {1'b0, op_a ^ b};
      OP_NOP:    alu_res = res_q;
      OP_CLR:    alu_res = '0;
      OP_OR:     alu_res = {1'b0, op_a | b};
      OP_SWAP:   alu_res = {1'b0, b[W/2-1:0], b[W-1:W/2]};
      OP_SHL, OP_SHR: begin
        // a zero shift amount never enters the iterative path
        if (b[SHW-1:0] == '0) alu_res = {1'b0, op_a};
        else                  is_iter = 1'b1;
      end
`ifdef ALU_PIPE_MUL_EN
      OP_MUL: begin
        is_iter    = 1'b1;
        iter_state = MUL;
      end
`endif
      default:   alu_err = 1'b1;
    endcase
  end

  alu_pipe_iter #(.W(W), .SHW(SHW)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (accept && is_iter),
    .op     (op),
    .a      (op_a),
    .b      (b),
    .done   (iter_done),
    .result (iter_res)
  );

  always_comb begin
    state_d     = state_q;
    res_d       = res_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (accept) begin
      if (is_iter) begin
        state_d = iter_state;
      end else begin
        res_d       = alu_res;
        err_d       = alu_err;
        out_valid_d = 1'b1;
      end
    end else if (state_q != IDLE && iter_done) begin
      res_d       = iter_res;
      err_d       = 1'b0;
      out_valid_d = 1'b1;
      state_d     = IDLE;
    end
    zero_d = (res_d[W-1:0] == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      res_q       <= '0;
      zero_q      <= 1'b1;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (W=8): vector table, scoreboard, and multi-cycle corner cases.
module tb_alu_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         a_sel = 1'b0;
  logic         out_ready = 1'b1;
  logic [3:0]   inst = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, zero, err;
  logic [W:0]   res;

  alu_pipe #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inst      (inst),
    .a_sel     (a_sel),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .zero      (zero),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [W:0] res;
    logic       err;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         asel;
    logic [W:0]   res;
    logic         err;
    int           lat;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Result monitor: a new result is out_valid after idle or right after a drain.
  logic prev_valid = 1'b0;
  logic prev_drain = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    if (out_valid && (!prev_valid || prev_drain)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got res %h expected none", res);
      end else begin
        e = sb.pop_front();
        $display("result res=%h zero=%b err=%b cyc=%0d (want res=%h cyc=%0d)",
                 res, zero, err, cyc, e.res, e.cyc);
        check("res", res, e.res);
        check("zero", zero, (e.res[W-1:0] == '0));
        check("err", err, e.err);
        check("latency", cyc, e.cyc);
      end
    end
    prev_valid = out_valid;
    prev_drain = out_valid && out_ready;
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic asel, input logic [W:0] eres, input logic eerr,
                       input int lat, input bit track, output int waited);
    in_valid = 1'b1;
    inst     = op;
    a        = av;
    b        = bv;
    a_sel    = asel;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1 (op %0d)", op);
    end else begin
      if (track) sb.push_back('{eres, eerr, cyc + lat});
      $display("issue op=%0d a=%h b=%h a_sel=%b cyc=%0d", op, av, bv, asel, cyc);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_sel    = 1'b0;
  endtask

  vec_t vecs[21];
  int   w;
  bit   ok;

  initial begin
    vecs[0]  = '{4'd2,  8'hF0, 8'h20, 1'b0, 9'h110, 1'b0, 1};
    vecs[1]  = '{4'd3,  8'h05, 8'h06, 1'b0, 9'h1FF, 1'b0, 1};
    vecs[2]  = '{4'd0,  8'h00, 8'h5A, 1'b0, 9'h05A, 1'b0, 1};
    vecs[3]  = '{4'd1,  8'hC3, 8'h00, 1'b0, 9'h0C3, 1'b0, 1};
    vecs[4]  = '{4'd4,  8'hF0, 8'h3C, 1'b0, 9'h030, 1'b0, 1};
    vecs[5]  = '{4'd5,  8'h00, 8'h0F, 1'b0, 9'h010, 1'b0, 1};
    vecs[6]  = '{4'd2,  8'hFF, 8'h01, 1'b1, 9'h011, 1'b0, 1};
    vecs[7]  = '{4'd6,  8'h00, 8'h00, 1'b0, 9'h1FF, 1'b0, 1};
    vecs[8]  = '{4'd7,  8'hAA, 8'hFF, 1'b0, 9'h055, 1'b0, 1};
    vecs[9]  = '{4'd8,  8'h11, 8'h22, 1'b0, 9'h055, 1'b0, 1};
    vecs[10] = '{4'd9,  8'h12, 8'h34, 1'b0, 9'h000, 1'b0, 1};
    vecs[11] = '{4'd10, 8'hA0, 8'h05, 1'b0, 9'h0A5, 1'b0, 1};
    vecs[12] = '{4'd11, 8'h00, 8'hA5, 1'b0, 9'h05A, 1'b0, 1};
    vecs[13] = '{4'd12, 8'h81, 8'h03, 1'b0, 9'h008, 1'b0, 4};
    vecs[14] = '{4'd12, 8'h81, 8'h01, 1'b0, 9'h102, 1'b0, 2};
    vecs[15] = '{4'd12, 8'h81, 8'h00, 1'b0, 9'h081, 1'b0, 1};
    vecs[16] = '{4'd13, 8'h81, 8'h07, 1'b0, 9'h001, 1'b0, 8};
    vecs[17] = '{4'd13, 8'h81, 8'h01, 1'b0, 9'h140, 1'b0, 2};
    vecs[18] = '{4'd15, 8'h12, 8'h34, 1'b0, 9'h000, 1'b1, 1};
    vecs[19] = '{4'd5,  8'h00, 8'hFF, 1'b0, 9'h100, 1'b0, 1};
    vecs[20] = '{4'd13, 8'hFF, 8'h0C, 1'b1, 9'h000, 1'b0, 5};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_res", res, 9'h000);
    check("rst_zero", zero, 1'b1);
    check("rst_err", err, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Back-to-back vector table
    for (int i = 0; i < 21; i++)
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].asel, vecs[i].res, vecs[i].err,
            vecs[i].lat, 1'b1, w);

`ifdef ALU_PIPE_MUL_EN
    issue(4'd14, 8'h10, 8'h11, 1'b0, 9'h110, 1'b0, 9, 1'b1, w);
    issue(4'd14, 8'h03, 8'h05, 1'b0, 9'h00F, 1'b0, 9, 1'b1, w);
`else
    issue(4'd14, 8'h10, 8'h11, 1'b0, 9'h000, 1'b1, 1, 1'b1, w);
`endif

    // Backpressure: result must hold and no second accept until drained
    repeat (12) @(posedge clk);
    #1;
    out_ready = 1'b0;
    issue(4'd7, 8'h0F, 8'hF0, 1'b0, 9'h0FF, 1'b0, 1, 1'b1, w);
    in_valid = 1'b1;
    inst     = 4'd2;
    a        = 8'h01;
    b        = 8'h01;
    repeat (4) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_res_hold", res, 9'h0FF);
      check("bp_valid_hold", out_valid, 1'b1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(4'd2, 8'h01, 8'h01, 1'b0, 9'h002, 1'b0, 1, 1'b1, w);
    check("drain_accept_wait", w, 0);

    // Reset in the 3rd cycle of an SHR by 7
    repeat (3) @(posedge clk);
    #1;
    issue(4'd0, 8'h00, 8'h77, 1'b0, 9'h077, 1'b0, 1, 1'b1, w);
    repeat (3) @(posedge clk);
    #1;
    issue(4'd13, 8'hFF, 8'h07, 1'b0, 9'h000, 1'b0, 0, 1'b0, w);
    @(negedge clk);
    check("busy_res_hold", res, 9'h077);
    check("busy_valid", out_valid, 1'b0);
    check("busy_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_res", res, 9'h000);
    check("abort_zero", zero, 1'b1);
    check("abort_err", err, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    ok = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) ok = 1'b0;
    end
    check("abort_no_output", ok, 1'b1);

    repeat (5) @(posedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
